uart_rx_frame_assembler: RTL and testbench
==========================================

Name: uart_rx_frame_assembler

Overview:
Sits downstream of the UART byte receiver and alongside the 2 ms inter-frame gap counter. Collects received bytes into a frame buffer. Drives the gap counter's reset/enable so that it restarts on every byte. Closes the frame when the counter reports a >2 ms line-idle gap, then presents the frame (length, error flag, byte read port) to the protocol layer until it is acknowledged.

Parameters:
DEPTH, 16, maximum frame length in bytes (power of 2, 4..256)
DATA_W, 8, byte width
LEN_W, clog2(DEPTH+1) = 5, width of length/pointer fields

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
rx_data  in  DATA_W  received byte, valid with rx_valid
rx_valid  in  1  one-cycle strobe per received byte
rx_err  in  1  framing/parity error for the byte, qualified by rx_valid
gap_in  in  1  idle-gap flag from the 2 ms counter (level, high = gap elapsed)
gap_rst  out  1  active-high synchronous restart to the 2 ms counter
gap_ena  out  1  count enable to the 2 ms counter
frame_valid  out  1  complete frame available
frame_len  out  LEN_W  number of stored bytes, stable while frame_valid
frame_err  out  1  frame contained an rx_err byte or overflowed, stable while frame_valid
rd_en  in  1  read request for next frame byte
rd_data  out  DATA_W  frame byte, registered
rd_dv  out  1  rd_data valid strobe (1 cycle)
rd_empty  out  1  no unread bytes in presented frame
drop_pulse  out  1  one-cycle strobe: byte discarded (overflow or frame held)

Behaviour:
- Reset (rst=0, async): state IDLE; write/read pointers and length = 0; err flags cleared.
  Outputs: frame_valid=0, frame_len=0, frame_err=0, rd_dv=0, rd_data=0, drop_pulse=0, gap_ena=0, rd_empty=1, gap_rst=1.
  Reset mid-frame or mid-read discards all content.
- States: IDLE, COLLECT, READY.
- IDLE:
  - gap_rst=1, gap_ena=0.
  - rx_valid: store byte at index 0, len=1, err |= rx_err, go COLLECT.
- COLLECT:
  - gap_ena=1.
  - Every rx_valid: gap_rst=1 for that cycle (registered, so counter restarts on the next edge) and byte stored at index len.
  - len < DEPTH: len += 1.
  - len == DEPTH: byte discarded, drop_pulse=1, err=1, gap still restarted.
  - gap_in=1 with no rx_valid in the same cycle: go READY next cycle. frame_valid=1, frame_len=len, frame_err=err.
  - gap_in=1 and rx_valid together: byte wins, gap ignored, stay COLLECT.
- READY:
  - gap_rst=1, gap_ena=0.
  - rx_valid: byte discarded, drop_pulse=1. The presented frame is unaffected.
  - rd_en with rd_empty=0: rd_data = buf[rd_ptr] and rd_dv=1 on the next cycle; rd_ptr += 1.
  - rd_en with rd_empty=1: ignored, rd_dv=0.
  - rd_empty = (rd_ptr == len) in READY, 1 in other states.
  - frame_ack: next cycle go IDLE; frame_valid=0, len/ptrs/err cleared. frame_ack has priority over a same-cycle rd_en.
  - frame_ack outside READY: ignored.
- Length rule: len saturates at DEPTH and never wraps. frame_len=DEPTH is legal.
- Latency:
  - Last byte to frame_valid = gap detection time + 1 cycle.
  - rd_en to rd_dv = 1 cycle.
- Missing port, listed here: frame_ack  in  1  consumer releases the frame.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_READY=2'd2
  - DEPTH/DATA_W defaults
  - LEN_W derivation function
- One sub-module: frame_buf_rf, a DEPTH x DATA_W register file with synchronous write port (we, waddr, wdata) and registered read port (re, raddr, rdata). No reset on the storage array.

Test Plan:
- Send 5 bytes 0x11..0x15 one every 10 cycles, then raise gap_in -> frame_valid=1, frame_len=5, frame_err=0; 5 rd_en pulses return 0x11..0x15 with rd_dv one cycle later; rd_empty=1 after the 5th read.
- Assert gap_in and rx_valid (0xAA) in the same cycle during COLLECT -> no READY transition; byte 0xAA stored; gap_rst pulses.
- Send 18 bytes with DEPTH=16 -> frame_len=16, frame_err=1, drop_pulse high exactly twice.
- Send 3 bytes, the 2nd with rx_err=1, then gap -> frame_len=3, frame_err=1.
- In READY, send rx_valid byte 0x55, then read all bytes and frame_ack -> drop_pulse=1 once; contents unchanged; IDLE with rd_empty=1, gap_rst=1 after ack.
- Drive rst=0 asynchronously mid-COLLECT (3 bytes stored) -> outputs immediately at reset values; the next byte after release starts a frame with len=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame assembler: FSM encoding,
// default sizes and the length-field width derivation.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    localparam int DEPTH_DEF  = 16;
    localparam int DATA_W_DEF = 8;

    // Length must be able to hold DEPTH itself, hence the +1.
    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/frame_buf_rf.sv
// Frame byte store: synchronous write, registered read. The array itself is
// never reset; only the read register is cleared.
module frame_buf_rf #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// Collects received UART bytes into a frame, closes it on a line-idle gap and
// presents it to the protocol layer until acknowledged.
module uart_rx_frame_assembler
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = len_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    input  logic              gap_in,
    output logic              gap_rst,
    output logic              gap_ena,
    output logic              frame_valid,
    output logic [LEN_W-1:0]  frame_len,
    output logic              frame_err,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_dv,
    output logic              rd_empty,
    output logic              drop_pulse,
    input  logic              frame_ack
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  ptr_q, ptr_d;
    logic              err_q, err_d;
    logic              drop_d, gap_rst_d;
    logic              we, re;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            drop_pulse <= 1'b0;
            gap_rst    <= 1'b1;
            rd_dv      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            drop_pulse <= drop_d;
            gap_rst    <= gap_rst_d;
            rd_dv      <= re;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        drop_d    = 1'b0;
        gap_rst_d = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                gap_rst_d = 1'b1;
                if (rx_valid) begin
                    we      = 1'b1;
                    len_d   = LEN_ONE;
                    err_d   = rx_err;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // A byte always beats a same-cycle gap and restarts the counter.
                if (rx_valid) begin
                    gap_rst_d = 1'b1;
                    err_d     = err_q | rx_err;
                    if (len_q == LEN_MAX) begin
                        drop_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        we    = 1'b1;
                        len_d = len_q + LEN_ONE;
                    end
                end else if (gap_in) begin
                    gap_rst_d = 1'b1;
                    state_d   = ST_READY;
                end
            end
            ST_READY: begin
                gap_rst_d = 1'b1;
                drop_d    = rx_valid;
                if (frame_ack) begin
                    state_d = ST_IDLE;
                    len_d   = '0;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end else if (rd_en && !rd_empty) begin
                    re    = 1'b1;
                    ptr_d = ptr_q + LEN_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gap_ena     = (state_q == ST_COLLECT);
    assign frame_valid = (state_q == ST_READY);
    assign frame_len   = frame_valid ? len_q : '0;
    assign frame_err   = frame_valid & err_q;
    assign rd_empty    = !frame_valid || (ptr_q == len_q);

    frame_buf_rf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (len_q[AW-1:0]),
        .wdata (rx_data),
        .re    (re),
        .raddr (ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Directed bench for the frame assembler with a byte scoreboard; expected
// frame bytes are queued as they are sent and popped on each rd_dv.
module tb_uart_rx_frame_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       gap_in = 1'b0;
    logic       gap_rst, gap_ena, frame_valid, frame_err;
    logic [4:0] frame_len;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_dv, rd_empty, drop_pulse;
    logic       frame_ack = 1'b0;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         drop_cnt = 0;
    int         drop_base;
    logic [7:0] sb [$];

    uart_rx_frame_assembler dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .gap_in      (gap_in),
        .gap_rst     (gap_rst),
        .gap_ena     (gap_ena),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .frame_err   (frame_err),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_dv       (rd_dv),
        .rd_empty    (rd_empty),
        .drop_pulse  (drop_pulse),
        .frame_ack   (frame_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (drop_pulse) drop_cnt <= drop_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic e, input bit store);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_err   = e;
        if (store) sb.push_back(d);
        tick();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic gap();
        gap_in = 1'b1;
        tick();
        gap_in = 1'b0;
    endtask

    task automatic read_byte(input string tag);
        logic [7:0] exp;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_dv"}, rd_dv, 1);
        check({tag, "_sb_has_data"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, "_data"}, rd_data, exp);
        end
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rd_dv", rd_dv, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_drop", drop_pulse, 0);
        check("rst_gap_ena", gap_ena, 0);
        check("rst_rd_empty", rd_empty, 1);
        check("rst_gap_rst", gap_rst, 1);
        rst = 1'b1;
        tick();

        // Basic 5-byte frame, bytes 10 cycles apart
        drop_base = drop_cnt;
        for (int i = 0; i < 5; i++) begin
            send(8'h11 + 8'(i), 1'b0, 1'b1);
            if (i == 0) begin
                check("t1_gap_ena", gap_ena, 1);
                check("t1_gap_rst_byte", gap_rst, 1);
            end
            repeat (9) tick();
            if (i == 0) check("t1_gap_rst_idle", gap_rst, 0);
        end
        check("t1_not_valid_yet", frame_valid, 0);
        gap();
        check("t1_frame_valid", frame_valid, 1);
        check("t1_frame_len", frame_len, 5);
        check("t1_frame_err", frame_err, 0);
        check("t1_gap_ena_ready", gap_ena, 0);
        for (int i = 0; i < 5; i++) begin
            check("t1_rd_empty_before", rd_empty, 0);
            read_byte("t1_rd");
        end
        check("t1_rd_empty_after", rd_empty, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t1_rd_on_empty_dv", rd_dv, 0);
        check("t1_no_drops", drop_cnt - drop_base, 0);
        ack();
        check("t1_ack_valid", frame_valid, 0);

        // Gap and byte in the same cycle: byte wins
        send(8'h01, 1'b0, 1'b1);
        tick();
        gap_in = 1'b1;
        send(8'hAA, 1'b0, 1'b1);
        gap_in = 1'b0;
        check("t2_stay_collect", frame_valid, 0);
        check("t2_gap_rst_pulse", gap_rst, 1);
        tick();
        check("t2_gap_rst_low", gap_rst, 0);
        check("t2_still_collect", gap_ena, 1);
        gap();
        check("t2_frame_len", frame_len, 2);
        read_byte("t2_rd0");
        read_byte("t2_rd1");
        ack();

        // Overflow: 18 bytes into a 16-deep frame
        drop_base = drop_cnt;
        for (int i = 0; i < 18; i++) send(8'h20 + 8'(i), 1'b0, i < 16);
        tick();
        check("t3_drop_count", drop_cnt - drop_base, 2);
        gap();
        check("t3_frame_len", frame_len, 16);
        check("t3_frame_err", frame_err, 1);
        for (int i = 0; i < 16; i++) read_byte("t3_rd");
        check("t3_rd_empty", rd_empty, 1);
        ack();

        // Error byte in middle of frame
        send(8'h31, 1'b0, 1'b1);
        send(8'h32, 1'b1, 1'b1);
        send(8'h33, 1'b0, 1'b1);
        gap();
        check("t4_frame_len", frame_len, 3);
        check("t4_frame_err", frame_err, 1);
        for (int i = 0; i < 3; i++) read_byte("t4_rd");
        ack();
        check("t4_err_cleared", frame_err, 0);

        // Byte arriving while frame held is dropped
        send(8'h61, 1'b0, 1'b1);
        send(8'h62, 1'b0, 1'b1);
        gap();
        drop_base = drop_cnt;
        send(8'h55, 1'b0, 1'b0);
        tick();
        check("t5_drop_once", drop_cnt - drop_base, 1);
        check("t5_len_kept", frame_len, 2);
        check("t5_err_kept", frame_err, 0);
        read_byte("t5_rd0");
        read_byte("t5_rd1");
        check("t5_empty", rd_empty, 1);
        ack();
        check("t5_idle_valid", frame_valid, 0);
        check("t5_idle_empty", rd_empty, 1);
        check("t5_idle_gap_rst", gap_rst, 1);
        check("t5_idle_gap_ena", gap_ena, 0);

        // Asynchronous reset mid-collect
        send(8'h71, 1'b0, 1'b0);
        send(8'h72, 1'b0, 1'b0);
        send(8'h73, 1'b0, 1'b0);
        check("t6_collecting", gap_ena, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_async_gap_ena", gap_ena, 0);
        check("t6_async_gap_rst", gap_rst, 1);
        check("t6_async_valid", frame_valid, 0);
        check("t6_async_empty", rd_empty, 1);
        #4 rst = 1'b1;
        tick();
        send(8'h77, 1'b0, 1'b1);
        gap();
        check("t6_frame_len", frame_len, 1);
        check("t6_frame_err", frame_err, 0);
        read_byte("t6_rd");
        ack();
        check("t6_sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
